contador_mn: RTL and testbench

- Parametrised successor of the module-M counter used by the game timers and sequencers.
- Adds up/down direction, synchronous load and clear, a built-in prescaler, wrap or saturate mode, and extra status flags.
- Lets one instance implement round timers, vote countdowns and player-index walkers without external glue.

---
 rtl/contador_mn_pkg.sv | 17 +
 rtl/prescaler_m.sv | 38 +++
 rtl/contador_mn.sv | 93 +++++++++
 tb/tb_contador_mn.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/contador_mn_pkg.sv
// Shared constants and helpers for the contador_mn counter family.
package contador_mn_pkg;

  localparam logic SOBE  = 1'b0;
  localparam logic DESCE = 1'b1;

  localparam int WRAP   = 0;
  localparam int SATURA = 1;

  function automatic int clog2(input int valor);
    int r;
    r = 0;
    while ((1 << r) < valor) r++;
    return r;
  endfunction

endpackage

// File: rtl/prescaler_m.sv
// Divide-by-P enable prescaler: tick strobes once per P cycles with conta high.
module prescaler_m #(
  parameter int P = 1
) (
  input  logic clock,
  input  logic zera_n,
  input  logic zera_s,
  input  logic conta,
  output logic tick
);
  import contador_mn_pkg::*;

  localparam int W = (clog2(P) > 1) ? clog2(P) : 1;
  localparam logic [W-1:0] PRE_MAX = W'(P - 1);

  logic [W-1:0] pre_reg;
  logic [W-1:0] pre_next;

  assign tick = conta & (pre_reg == PRE_MAX);

  always_comb begin
    pre_next = pre_reg;
    if (zera_s)
      pre_next = '0;
    else if (tick)
      pre_next = '0;
    else if (conta)
      pre_next = pre_reg + 1'b1;
  end

  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n)
      pre_reg <= '0;
    else
      pre_reg <= pre_next;
  end

endmodule

// File: rtl/contador_mn.sv
// Modulo-M up/down counter with prescaler, load/clear, wrap or saturate mode
// and boundary status flags.
module contador_mn #(
  parameter int M      = 100,
  parameter int N      = 7,
  parameter int P      = 1,
  parameter int SATURA = 0
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         zera_s,
  input  logic         carrega,
  input  logic [N-1:0] D,
  input  logic         conta,
  input  logic         desce,
  output logic [N-1:0] Q,
  output logic         tick,
  output logic         fim,
  output logic         inicio,
  output logic         meio,
  output logic         tc
);
  import contador_mn_pkg::*;

  localparam logic [N-1:0] Q_MAX  = N'(M - 1);
  localparam logic [N-1:0] Q_MEIO = N'(M / 2);
  localparam logic [N:0]   M_EXT  = (N + 1)'(M);

  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;
  logic [N-1:0] d_clamp;
  logic         tc_reg;
  logic         tc_next;

  // A load also restarts the prescaler so partial progress is discarded.
  prescaler_m #(
    .P(P)
  ) u_prescaler (
    .clock  (clock),
    .zera_n (zera_n),
    .zera_s (zera_s | carrega),
    .conta  (conta),
    .tick   (tick)
  );

  // Out-of-range loads clamp to the top of the range.
  assign d_clamp = ({1'b0, D} >= M_EXT) ? Q_MAX : D;

  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    if (zera_s) begin
      q_next = '0;
    end else if (carrega) begin
      q_next = d_clamp;
    end else if (tick) begin
      if (desce == SOBE) begin
        if (q_reg == Q_MAX) begin
          tc_next = 1'b1;
          if (SATURA == WRAP)
            q_next = '0;
        end else begin
          q_next = q_reg + 1'b1;
        end
      end else begin
        if (q_reg == '0) begin
          tc_next = 1'b1;
          if (SATURA == WRAP)
            q_next = Q_MAX;
        end else begin
          q_next = q_reg - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      q_reg  <= '0;
      tc_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      tc_reg <= tc_next;
    end
  end

  assign Q      = q_reg;
  assign tc     = tc_reg;
  assign fim    = (q_reg == Q_MAX);
  assign inicio = (q_reg == '0);
  assign meio   = (q_reg == Q_MEIO);

endmodule

// File: tb/tb_contador_mn.sv
// Directed bench for contador_mn: four configurations, scoreboard of expected
// post-edge states, immediate assertions at every comparison.
module tb_contador_mn;

  localparam int MU [4] = '{10, 10, 10, 7};

  typedef struct {
    int         u;
    logic [6:0] q;
    logic       tc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       clock = 1'b0;
  logic       zera_n;
  logic       zs [4];
  logic       ld [4];
  logic [6:0] dd [4];
  logic       cn [4];
  logic       dn [4];
  logic [6:0] q_o [4];
  logic       tick_o [4];
  logic       fim_o [4];
  logic       ini_o [4];
  logic       meio_o [4];
  logic       tc_o [4];

  always #5 clock = ~clock;

  // unit 0: M=10 P=1 wrap
  contador_mn #(.M(10), .N(7), .P(1), .SATURA(0)) u0 (
    .clock(clock), .zera_n(zera_n), .zera_s(zs[0]), .carrega(ld[0]), .D(dd[0]),
    .conta(cn[0]), .desce(dn[0]), .Q(q_o[0]), .tick(tick_o[0]), .fim(fim_o[0]),
    .inicio(ini_o[0]), .meio(meio_o[0]), .tc(tc_o[0]));

  // unit 1: M=10 P=3 wrap
  contador_mn #(.M(10), .N(7), .P(3), .SATURA(0)) u1 (
    .clock(clock), .zera_n(zera_n), .zera_s(zs[1]), .carrega(ld[1]), .D(dd[1]),
    .conta(cn[1]), .desce(dn[1]), .Q(q_o[1]), .tick(tick_o[1]), .fim(fim_o[1]),
    .inicio(ini_o[1]), .meio(meio_o[1]), .tc(tc_o[1]));

  // unit 2: M=10 P=1 saturate
  contador_mn #(.M(10), .N(7), .P(1), .SATURA(1)) u2 (
    .clock(clock), .zera_n(zera_n), .zera_s(zs[2]), .carrega(ld[2]), .D(dd[2]),
    .conta(cn[2]), .desce(dn[2]), .Q(q_o[2]), .tick(tick_o[2]), .fim(fim_o[2]),
    .inicio(ini_o[2]), .meio(meio_o[2]), .tc(tc_o[2]));

  // unit 3: M=7 P=1 wrap
  contador_mn #(.M(7), .N(7), .P(1), .SATURA(0)) u3 (
    .clock(clock), .zera_n(zera_n), .zera_s(zs[3]), .carrega(ld[3]), .D(dd[3]),
    .conta(cn[3]), .desce(dn[3]), .Q(q_o[3]), .tick(tick_o[3]), .fim(fim_o[3]),
    .inicio(ini_o[3]), .meio(meio_o[3]), .tc(tc_o[3]));

  task automatic push(input int u, input int qv, input logic tcv, input string tag);
    exp_t e;
    e.u   = u;
    e.q   = 7'(qv);
    e.tc  = tcv;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic fe, ie, me;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      fe = (int'(e.q) == MU[e.u] - 1);
      ie = (e.q == 7'd0);
      me = (int'(e.q) == MU[e.u] / 2);
      checks++;
      assert (q_o[e.u] === e.q) else begin
        errors++;
        $error("FAIL %s u%0d Q got %0d expected %0d", e.tag, e.u, q_o[e.u], e.q);
      end
      checks++;
      assert (tc_o[e.u] === e.tc) else begin
        errors++;
        $error("FAIL %s u%0d tc got %b expected %b", e.tag, e.u, tc_o[e.u], e.tc);
      end
      checks++;
      assert (fim_o[e.u] === fe) else begin
        errors++;
        $error("FAIL %s u%0d fim got %b expected %b", e.tag, e.u, fim_o[e.u], fe);
      end
      checks++;
      assert (ini_o[e.u] === ie) else begin
        errors++;
        $error("FAIL %s u%0d inicio got %b expected %b", e.tag, e.u, ini_o[e.u], ie);
      end
      checks++;
      assert (meio_o[e.u] === me) else begin
        errors++;
        $error("FAIL %s u%0d meio got %b expected %b", e.tag, e.u, meio_o[e.u], me);
      end
      $display("txn %s u%0d Q=%0d tc=%b fim=%b inicio=%b meio=%b", e.tag, e.u,
               q_o[e.u], tc_o[e.u], fim_o[e.u], ini_o[e.u], meio_o[e.u]);
    end
  endtask

  task automatic check_tick(input int u, input logic exp, input string tag);
    #1;
    checks++;
    assert (tick_o[u] === exp) else begin
      errors++;
      $error("FAIL %s u%0d tick got %b expected %b", tag, u, tick_o[u], exp);
    end
  endtask

  task automatic edge_and_check();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    zera_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      zs[i] = 1'b0; ld[i] = 1'b0; dd[i] = 7'd0; cn[i] = 1'b0; dn[i] = 1'b0;
    end
    #2;
    for (int u = 0; u < 4; u++) begin
      push(u, 0, 1'b0, "reset");
      check_tick(u, 1'b0, "reset_tick");
    end
    check_all();
    @(negedge clock);
    zera_n = 1'b1;

    // Unit 0: count up through the wrap
    cn[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check_tick(0, 1'b1, "up_tick");
      push(0, (i + 1) % 10, (i == 9), "up_wrap");
      edge_and_check();
    end
    cn[0] = 1'b0;

    // Unit 1: prescaler by 3, hold, resume
    cn[1] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check_tick(1, (i % 3 == 2), "pre_tick");
      push(1, (i + 1) / 3, 1'b0, "pre_count");
      edge_and_check();
    end
    cn[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_tick(1, 1'b0, "pre_hold_tick");
      push(1, 3, 1'b0, "pre_hold");
      edge_and_check();
    end
    cn[1] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      check_tick(1, (r == 2), "pre_resume_tick");
      push(1, (r == 2) ? 4 : 3, 1'b0, "pre_resume");
      edge_and_check();
    end
    // Load mid-prescale restarts the prescaler
    check_tick(1, 1'b0, "pre_partial_tick");
    push(1, 4, 1'b0, "pre_partial");
    edge_and_check();
    ld[1] = 1'b1; dd[1] = 7'd7;
    push(1, 7, 1'b0, "pre_load");
    edge_and_check();
    ld[1] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      check_tick(1, (r == 2), "pre_after_load_tick");
      push(1, (r == 2) ? 8 : 7, 1'b0, "pre_after_load");
      edge_and_check();
    end
    cn[1] = 1'b0;

    // Unit 2: saturate at 0 counting down
    ld[2] = 1'b1; dd[2] = 7'd1;
    push(2, 1, 1'b0, "sat_load");
    edge_and_check();
    ld[2] = 1'b0; dn[2] = 1'b1; cn[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(2, 0, (i > 0), "sat_down");
      edge_and_check();
    end
    cn[2] = 1'b0;
    push(2, 0, 1'b0, "sat_idle");
    edge_and_check();

    // Unit 0: load clamp and clear-over-load priority
    ld[0] = 1'b1; dd[0] = 7'd15;
    push(0, 9, 1'b0, "load_clamp");
    edge_and_check();
    zs[0] = 1'b1; dd[0] = 7'd4;
    push(0, 0, 1'b0, "clear_over_load");
    edge_and_check();
    zs[0] = 1'b0;
    push(0, 4, 1'b0, "load_4");
    edge_and_check();
    dd[0] = 7'd6;
    push(0, 6, 1'b0, "load_6");
    edge_and_check();
    ld[0] = 1'b0;

    // Asynchronous reset between edges
    cn[0] = 1'b1;
    #1 zera_n = 1'b0;
    #1;
    push(0, 0, 1'b0, "async_reset");
    check_all();
    #1 zera_n = 1'b1;
    push(0, 1, 1'b0, "after_reset");
    edge_and_check();
    cn[0] = 1'b0;

    // Unit 3: M=7 counting down from reset wraps to 6
    push(3, 0, 1'b0, "m7_start");
    check_all();
    dn[3] = 1'b1; cn[3] = 1'b1;
    push(3, 6, 1'b1, "m7_wrap");
    edge_and_check();
    push(3, 5, 1'b0, "m7_down");
    edge_and_check();
    push(3, 4, 1'b0, "m7_down");
    edge_and_check();
    cn[3] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
